// File: rtl/kbd_scan_sequencer_if.sv
// Bus bundle for kbd_scan_sequencer: PS/2 scancode input, converter
// strobe/result pair, and the CPU keycode ready/ack handshake.
// The sequencer connects through the slave modport and its environment
// through the master modport.
interface kbd_scan_sequencer_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       scan_ready;

    logic       conv_strobe;
    logic [7:0] conv_code;
    logic       conv_done;
    logic [7:0] conv_keycode;

    logic       kbd_ready;
    logic [7:0] kbd_keycode;
    logic       kbd_ack;

    logic       overflow;
    logic       ovf_clr;

    modport slave (
        input  scan_valid, scan_code, conv_done, conv_keycode, kbd_ack, ovf_clr,
        output scan_ready, conv_strobe, conv_code, kbd_ready, kbd_keycode, overflow
    );

    modport master (
        output scan_valid, scan_code, conv_done, conv_keycode, kbd_ack, ovf_clr,
        input  scan_ready, conv_strobe, conv_code, kbd_ready, kbd_keycode, overflow
    );
endinterface

// File: rtl/kbd_scan_sequencer.sv
// kbd_scan_sequencer: buffers raw PS/2 scancode bytes, feeds them one at a
// time to scancode_convert with a fixed quiet gap after every strobe, and
// queues the resulting keycodes for the CPU keyboard register.
// Synchronous active-low reset.
// Build option KBD_OUT_FIFO_EN: when defined the keycode queue is a FIFO of
// depth 2**OUT_DEPTH_LOG2; otherwise it is a single holding register.
module kbd_scan_sequencer #(
    parameter int IN_DEPTH_LOG2  = 3,
    parameter int GAP            = 100,
    parameter int OUT_DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    kbd_scan_sequencer_if.slave   bus
);

    localparam int                      IN_DEPTH   = 1 << IN_DEPTH_LOG2;
    localparam logic [IN_DEPTH_LOG2:0]  IN_FULL    = (IN_DEPTH_LOG2 + 1)'(IN_DEPTH);
    localparam logic [IN_DEPTH_LOG2-1:0] IN_PTR_ONE = 1;
    localparam logic [IN_DEPTH_LOG2:0]  IN_CNT_ONE = 1;
    localparam logic [OUT_DEPTH_LOG2:0] OUT_CNT_ONE = 1;
    localparam logic [7:0]              GAP_LOAD   = 8'(GAP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [7:0]               gap_cnt;
    logic [7:0]               gap_cnt_next;

    logic [7:0]               in_mem [IN_DEPTH];
    logic [IN_DEPTH_LOG2-1:0] in_wr_ptr;
    logic [IN_DEPTH_LOG2-1:0] in_rd_ptr;
    logic [IN_DEPTH_LOG2:0]   in_count;
    logic                     in_push;
    logic                     in_pop;
    logic                     in_drop;

    logic [7:0]               conv_code_q;

    logic [OUT_DEPTH_LOG2:0]  out_count;
    logic                     out_full;
    logic                     out_empty;
    logic                     out_push;
    logic                     out_pop;
    logic                     out_drop;
    logic [7:0]               out_head;

    logic                     overflow_q;

    // Scancode FIFO flags come from the registered count, so a byte offered
    // while full is dropped even if the sequencer pops on the same edge.
    assign bus.scan_ready = (in_count != IN_FULL);
    assign in_push        = bus.scan_valid && bus.scan_ready;
    assign in_drop        = bus.scan_valid && !bus.scan_ready;

    // Scancode storage; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= bus.scan_code;
        end
    end

    // Scancode FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else begin
            if (in_push) begin
                in_wr_ptr <= in_wr_ptr + IN_PTR_ONE;
            end
            if (in_pop) begin
                in_rd_ptr <= in_rd_ptr + IN_PTR_ONE;
            end
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + IN_CNT_ONE;
                2'b01:   in_count <= in_count - IN_CNT_ONE;
                default: in_count <= in_count;
            endcase
        end
    end

    // Sequencer state and quiet-gap counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
        end
    end

    // Next-state logic: one strobe per byte, then GAP quiet cycles before
    // the converter may see the next byte.
    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        in_pop       = 1'b0;
        case (state)
            IDLE: begin
                if (in_count != '0) begin
                    in_pop     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                gap_cnt_next = GAP_LOAD;
                state_next   = WAIT;
            end
            WAIT: begin
                gap_cnt_next = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                gap_cnt_next = '0;
            end
        endcase
    end

    // Converter byte register, loaded as the head byte leaves the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            conv_code_q <= '0;
        end else if (in_pop) begin
            conv_code_q <= in_mem[in_rd_ptr];
        end
    end

    assign bus.conv_strobe = (state == ISSUE);
    assign bus.conv_code   = conv_code_q;

    // Keycode queue control: an ack that frees the full queue on the same
    // edge lets the incoming keycode in.
    assign out_empty = (out_count == '0);
    assign out_pop   = bus.kbd_ack && !out_empty;
    assign out_push  = bus.conv_done && (!out_full || out_pop);
    assign out_drop  = bus.conv_done && out_full && !out_pop;

    // Keycode queue occupancy, shared by both queue builds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_count <= '0;
        end else begin
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + OUT_CNT_ONE;
                2'b01:   out_count <= out_count - OUT_CNT_ONE;
                default: out_count <= out_count;
            endcase
        end
    end

`ifdef KBD_OUT_FIFO_EN
    localparam int                        OUT_DEPTH   = 1 << OUT_DEPTH_LOG2;
    localparam logic [OUT_DEPTH_LOG2:0]   OUT_FULL    = (OUT_DEPTH_LOG2 + 1)'(OUT_DEPTH);
    localparam logic [OUT_DEPTH_LOG2-1:0] OUT_PTR_ONE = 1;

    logic [7:0]                out_mem [OUT_DEPTH];
    logic [OUT_DEPTH_LOG2-1:0] out_wr_ptr;
    logic [OUT_DEPTH_LOG2-1:0] out_rd_ptr;

    assign out_full = (out_count == OUT_FULL);
    assign out_head = out_mem[out_rd_ptr];

    // Keycode FIFO storage and pointers; storage is cleared so the head
    // reads as zero after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                out_mem[i] <= '0;
            end
        end else begin
            if (out_push) begin
                out_mem[out_wr_ptr] <= bus.conv_keycode;
                out_wr_ptr          <= out_wr_ptr + OUT_PTR_ONE;
            end
            if (out_pop) begin
                out_rd_ptr <= out_rd_ptr + OUT_PTR_ONE;
            end
        end
    end
`else
    logic [7:0] out_hold;

    assign out_full = (out_count != '0);
    assign out_head = out_hold;

    // Single holding register; a same-edge ack and push replaces the entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_hold <= '0;
        end else if (out_push) begin
            out_hold <= bus.conv_keycode;
        end
    end
`endif

    assign bus.kbd_ready   = !out_empty;
    assign bus.kbd_keycode = out_head;

    // Sticky drop flag; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (in_drop || out_drop) begin
            overflow_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_kbd_scan_sequencer.sv
// Directed testbench for kbd_scan_sequencer with GAP=100. A converter stub
// answers each strobe 10 cycles later with conv_code XOR 0x80. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_kbd_scan_sequencer;

`ifdef KBD_OUT_FIFO_EN
    localparam int QDEPTH = 4;
`else
    localparam int QDEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset;

    kbd_scan_sequencer_if bus ();

    kbd_scan_sequencer #(
        .IN_DEPTH_LOG2 (3),
        .GAP           (100),
        .OUT_DEPTH_LOG2(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         total_checks = 0;
    int         bad_checks   = 0;
    int         cyc          = 0;
    bit         stub_en      = 1'b0;
    logic [7:0] stub_code;
    logic [7:0] strobe_codes [$];
    int         strobe_cycs  [$];

    // Counts rising edges so strobe spacing can be measured.
    always @(posedge clk) cyc <= cyc + 1;

    // Records every converter strobe with its byte and cycle.
    always @(negedge clk) begin
        if (bus.conv_strobe === 1'b1) begin
            strobe_codes.push_back(bus.conv_code);
            strobe_cycs.push_back(cyc);
        end
    end

    // Converter stub: keycode = byte XOR 0x80, returned 10 cycles after the strobe.
    initial begin
        bus.conv_done    = 1'b0;
        bus.conv_keycode = 8'h00;
        forever begin
            @(negedge clk);
            if (stub_en && bus.conv_strobe === 1'b1) begin
                stub_code = bus.conv_code;
                repeat (10) @(negedge clk);
                bus.conv_done    = 1'b1;
                bus.conv_keycode = stub_code ^ 8'h80;
                @(negedge clk);
                bus.conv_done    = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        bus.scan_valid = 1'b1;
        bus.scan_code  = code;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset          = 1'b0;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        bus.kbd_ack    = 1'b0;
        bus.ovf_clr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushKeycode(input logic [7:0] k);
        bus.conv_done    = 1'b1;
        bus.conv_keycode = k;
        @(negedge clk);
        bus.conv_done    = 1'b0;
    endtask

    task automatic ackPulse();
        bus.kbd_ack = 1'b1;
        @(negedge clk);
        bus.kbd_ack = 1'b0;
    endtask

    task automatic waitReady(input string tag, input int limit);
        int n = 0;
        while (bus.kbd_ready !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, bus.kbd_ready}, 32'd1);
    endtask

    // Global time bound in case the design stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] t1_bytes [3];
        logic [7:0] t1_keys  [3];
        int         write_cyc;
        int         n;
        logic [7:0] exp_key;

        t1_bytes = '{8'h1c, 8'hf0, 8'h1c};
        t1_keys  = '{8'h9c, 8'h70, 8'h9c};

        reset = 1'b0;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
        bus.kbd_ack    = 1'b0;
        bus.ovf_clr    = 1'b0;
        @(negedge clk);

        // Reset values
        doReset();
        checkOutput("rst_strobe",   {31'd0, bus.conv_strobe}, 32'd0);
        checkOutput("rst_code",     {24'd0, bus.conv_code},   32'h00);
        checkOutput("rst_ready",    {31'd0, bus.kbd_ready},   32'd0);
        checkOutput("rst_keycode",  {24'd0, bus.kbd_keycode}, 32'h00);
        checkOutput("rst_scan_rdy", {31'd0, bus.scan_ready},  32'd1);
        checkOutput("rst_ovf",      {31'd0, bus.overflow},    32'd0);

        // Make / break / make sequence through the stub
        $display("[TB] make/break sequence");
        stub_en = 1'b1;
        strobe_codes.delete();
        strobe_cycs.delete();
        applyStimulus(t1_bytes[0]);
        write_cyc = cyc;
        applyStimulus(t1_bytes[1]);
        applyStimulus(t1_bytes[2]);
        bus.scan_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            waitReady("t1_wait_ready", 300);
            checkOutput("t1_keycode", {24'd0, bus.kbd_keycode}, {24'd0, t1_keys[i]});
            ackPulse();
        end
        waitCycles(120);
        checkOutput("t1_strobe_cnt", strobe_codes.size(), 32'd3);
        if (strobe_codes.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("t1_strobe_code", {24'd0, strobe_codes[i]}, {24'd0, t1_bytes[i]});
            end
            checkOutput("t1_first_latency", strobe_cycs[0] - write_cyc, 32'd1);
            checkOutput("t1_spacing_a", strobe_cycs[1] - strobe_cycs[0], 32'd102);
            checkOutput("t1_spacing_b", strobe_cycs[2] - strobe_cycs[1], 32'd102);
        end
        checkOutput("t1_ovf",   {31'd0, bus.overflow},  32'd0);
        checkOutput("t1_empty", {31'd0, bus.kbd_ready}, 32'd0);

        // Scancode FIFO overrun: 12 bytes with valid held
        $display("[TB] scancode FIFO overrun");
        stub_en = 1'b0;
        doReset();
        strobe_codes.delete();
        strobe_cycs.delete();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'(i + 1));
            checkOutput("t2_scan_ready", {31'd0, bus.scan_ready}, (i < 8) ? 32'd1 : 32'd0);
            if (i == 8) checkOutput("t2_ovf_before_drop", {31'd0, bus.overflow}, 32'd0);
            if (i == 9) checkOutput("t2_ovf_on_drop",     {31'd0, bus.overflow}, 32'd1);
        end
        bus.scan_valid = 1'b0;
        waitCycles(1000);
        checkOutput("t2_strobe_cnt", strobe_codes.size(), 32'd9);
        for (int i = 0; i < 9 && i < strobe_codes.size(); i++) begin
            checkOutput("t2_strobe_code", {24'd0, strobe_codes[i]}, i + 1);
        end
        checkOutput("t2_ovf_end",   {31'd0, bus.overflow},   32'd1);
        checkOutput("t2_scan_rdy",  {31'd0, bus.scan_ready}, 32'd1);

        // Keycode queue overrun with no CPU ack
        $display("[TB] keycode queue overrun, depth %0d", QDEPTH);
        stub_en = 1'b1;
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(8'(i + 1));
        bus.scan_valid = 1'b0;
        waitCycles(550);
        checkOutput("t3_ready",   {31'd0, bus.kbd_ready},   32'd1);
        checkOutput("t3_head",    {24'd0, bus.kbd_keycode}, 32'h81);
        checkOutput("t3_ovf_set", {31'd0, bus.overflow},    32'd1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        checkOutput("t3_ovf_clr", {31'd0, bus.overflow}, 32'd0);
        n = 0;
        while (bus.kbd_ready === 1'b1 && n < 8) begin
            checkOutput("t3_drain_key", {24'd0, bus.kbd_keycode}, 32'h81 + n);
            ackPulse();
            n++;
        end
        checkOutput("t3_held", n, QDEPTH);
        checkOutput("t3_ovf_after", {31'd0, bus.overflow}, 32'd0);

        // Full queue with ack and push on the same edge
        $display("[TB] simultaneous ack and push on full queue");
        stub_en = 1'b0;
        doReset();
        for (int k = 0; k < QDEPTH; k++) begin
            pushKeycode(8'(8'h40 + k));
            if (k == 0) begin
                checkOutput("t4_latency_ready", {31'd0, bus.kbd_ready},   32'd1);
                checkOutput("t4_latency_key",   {24'd0, bus.kbd_keycode}, 32'h40);
            end
        end
        checkOutput("t4_ovf_full", {31'd0, bus.overflow}, 32'd0);
        bus.conv_done    = 1'b1;
        bus.conv_keycode = 8'h55;
        bus.kbd_ack      = 1'b1;
        @(negedge clk);
        bus.conv_done    = 1'b0;
        bus.kbd_ack      = 1'b0;
        checkOutput("t4_ovf_simul", {31'd0, bus.overflow}, 32'd0);
        exp_key = (QDEPTH == 1) ? 8'h55 : 8'h41;
        checkOutput("t4_head", {24'd0, bus.kbd_keycode}, {24'd0, exp_key});
        n = 0;
        while (bus.kbd_ready === 1'b1 && n < 8) begin
            exp_key = (n == QDEPTH - 1) ? 8'h55 : 8'(8'h41 + n);
            checkOutput("t4_drain_key", {24'd0, bus.kbd_keycode}, {24'd0, exp_key});
            ackPulse();
            n++;
        end
        checkOutput("t4_count", n, QDEPTH);

        // Reset while waiting out the gap with bytes queued
        $display("[TB] reset during gap");
        doReset();
        pushKeycode(8'h33);
        checkOutput("t5_ready_pre", {31'd0, bus.kbd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h11 + i));
        bus.scan_valid = 1'b0;
        waitCycles(20);
        checkOutput("t5_code_pre", {24'd0, bus.conv_code}, 32'h11);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_strobe",   {31'd0, bus.conv_strobe}, 32'd0);
        checkOutput("t5_ready",    {31'd0, bus.kbd_ready},   32'd0);
        checkOutput("t5_scan_rdy", {31'd0, bus.scan_ready},  32'd1);
        checkOutput("t5_code",     {24'd0, bus.conv_code},   32'h00);
        reset = 1'b1;
        strobe_codes.delete();
        strobe_cycs.delete();
        waitCycles(300);
        checkOutput("t5_no_strobe", strobe_codes.size(), 32'd0);
        applyStimulus(8'h22);
        bus.scan_valid = 1'b0;
        waitCycles(5);
        checkOutput("t5_new_strobe_cnt", strobe_codes.size(), 32'd1);
        if (strobe_codes.size() > 0)
            checkOutput("t5_new_strobe_code", {24'd0, strobe_codes[0]}, 32'h22);

        // Ack on empty queue, then clear colliding with a drop
        $display("[TB] empty ack and clear/drop collision");
        ackPulse();
        checkOutput("t6_empty_ack", {31'd0, bus.kbd_ready}, 32'd0);
        pushKeycode(8'h66);
        checkOutput("t6_ready", {31'd0, bus.kbd_ready},   32'd1);
        checkOutput("t6_key",   {24'd0, bus.kbd_keycode}, 32'h66);
        for (int k = 1; k < QDEPTH; k++) pushKeycode(8'(8'h66 + k));
        checkOutput("t6_ovf_pre", {31'd0, bus.overflow}, 32'd0);
        bus.conv_done    = 1'b1;
        bus.conv_keycode = 8'h77;
        bus.ovf_clr      = 1'b1;
        @(negedge clk);
        bus.conv_done    = 1'b0;
        bus.ovf_clr      = 1'b0;
        checkOutput("t6_ovf_wins", {31'd0, bus.overflow},    32'd1);
        checkOutput("t6_head",     {24'd0, bus.kbd_keycode}, 32'h66);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        checkOutput("t6_ovf_clr", {31'd0, bus.overflow}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/kbd_scan_sequencer.md
# kbd_scan_sequencer

Sequences raw PS/2 scancode bytes into `scancode_convert` and buffers the resulting Lisp Machine keycodes for the CPU keyboard register. A scancode FIFO absorbs bursts from the PS/2 receiver. A small state machine issues one single-cycle strobe per byte, with a guaranteed quiet gap, so the converter's ROM lookup and modifier tracking settle between bytes. Converted keycodes are queued for the CPU behind a ready/ack handshake.

## Interface
Parameters:
- `IN_DEPTH_LOG2`, 3: scancode FIFO depth is 2**IN_DEPTH_LOG2 (8).
- `GAP`, 100: number of WAIT cycles after each converter strobe; legal range 1..255.
- `OUT_DEPTH_LOG2`, 2: keycode FIFO depth is 2**OUT_DEPTH_LOG2 (4). Used only with `KBD_OUT_FIFO_EN`.

Ports:
- `clk` in 1: system clock; the block has one clock.
- `reset` in 1: synchronous, active-low reset.
- `scan_valid` in 1: scancode byte present this cycle.
- `scan_code` in 8: raw PS/2 byte (make, `f0` break prefix, or `e0` extended prefix).
- `scan_ready` out 1: scancode FIFO not full.
- `conv_strobe` out 1: `strobe_in` to the converter.
- `conv_code` out 8: `code_in` to the converter.
- `conv_done` in 1: `strobe_out` from the converter.
- `conv_keycode` in 8: `keycode` from the converter.
- `kbd_ready` out 1: keycode available.
- `kbd_keycode` out 8: head-of-queue keycode.
- `kbd_ack` in 1: CPU consumed the head keycode.
- `overflow` out 1: sticky; an input byte or an output keycode was dropped.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- Reset (`reset`=0 at a clock edge): both FIFOs empty, state IDLE, WAIT counter 0, `overflow`=0. Outputs after reset: `conv_strobe`=0, `conv_code`=0, `kbd_ready`=0, `kbd_keycode`=0, `scan_ready`=1.
- Reset mid-operation discards all queued bytes and keycodes. `conv_strobe` is 0 from the cycle after the reset edge.

Scancode FIFO:
- Write when `scan_valid`=1 and `scan_ready`=1.
- `scan_valid`=1 while full: the byte is dropped and `overflow` is set. This holds even if a pop occurs on the same edge, because `scan_ready` is derived from the registered count.

State machine (states IDLE, ISSUE, WAIT):
- IDLE: if the scancode FIFO is non-empty, pop the head into the `conv_code` register and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `conv_strobe`=1 for exactly this one state. Load the counter with GAP and go to WAIT.
- WAIT: decrement the counter each cycle. At 1, go to IDLE.

Keycode capture:
- `conv_done` is captured in any state. `conv_keycode` is pushed into the keycode queue.
- Queue full and `conv_done`=1 with no same-edge `kbd_ack`: the keycode is dropped and `overflow` is set.
- Queue full and `conv_done`=1 with `kbd_ack`=1 on the same edge: the pop and the push both succeed.

CPU handshake:
- `kbd_ready` = queue non-empty. `kbd_keycode` = queue head.
- `kbd_ack`=1 pops one entry. `kbd_ack` while empty is ignored.

Overflow flag:
- `ovf_clr`=1 clears `overflow`.
- A set event on the same edge as `ovf_clr` wins, so `overflow` stays 1.

Pointers and counts:
- FIFO pointers wrap modulo depth.
- Counts are IN_DEPTH_LOG2+1 and OUT_DEPTH_LOG2+1 bits wide.

## Timing
- Byte written at edge N: the pop and IDLE→ISSUE happen at edge N+1. `conv_strobe`=1 and `conv_code` are valid during cycle N+1..N+2.
- Back-to-back strobes are exactly GAP+2 cycles apart (ISSUE 1, WAIT GAP, IDLE 1).
- `conv_done` sampled at edge M: `kbd_ready`=1 and `kbd_keycode` are valid after edge M (1-cycle latency).
- `kbd_ack` sampled at edge K: the next entry (or `kbd_ready`=0) is visible after edge K.
- `overflow` rises on the edge of the dropping event.

## Configuration
- `KBD_OUT_FIFO_EN` defined: the keycode queue is a FIFO of depth 2**OUT_DEPTH_LOG2.
- `KBD_OUT_FIFO_EN` undefined: the queue is a single holding register (depth 1), with identical full, drop and simultaneous-ack rules. A second keycode arriving before `kbd_ack` is dropped and sets `overflow`.

## Test plan
Defaults throughout (GAP=100). A converter stub returns `conv_keycode` = `conv_code` XOR 0x80, 10 cycles after each strobe.
- Bytes 0x1c, 0xf0, 0x1c written on consecutive edges → three `conv_strobe` pulses with `conv_code` 0x1c, 0xf0, 0x1c, spaced exactly 102 cycles apart. `kbd_keycode` sequence 0x9c, 0x70, 0x9c. `overflow`=0.
- 12 back-to-back bytes 0x01..0x0c with `scan_valid` held regardless of `scan_ready` → `scan_ready`=0 after edge 8. 0x0a..0x0c are dropped and `overflow`=1. Strobes carry 0x01..0x09 in order.
- No `kbd_ack`, 5 bytes sent (FIFO build) → `kbd_keycode` stays 0x81 (first keycode), 4 entries held, 5th dropped, `overflow`=1. `ovf_clr` → `overflow`=0.
- Queue full, `kbd_ack` pulsed on the same edge as `conv_done` → no drop, `overflow` stays 0, count stays 4. Without `KBD_OUT_FIFO_EN` the same check runs at depth 1.
- `reset`=0 pulsed while in WAIT with 3 bytes queued → after the edge `conv_strobe`=0, `kbd_ready`=0, `scan_ready`=1. No further strobes until a new byte arrives.
- `kbd_ack` while `kbd_ready`=0, and `ovf_clr` on the same edge as a drop → no state change from the ack, and `overflow`=1.
